// File: rtl/gpio_input_capture_pkg.sv
// Shared constants and helpers for the GPIO input capture block.
package gpio_input_capture_pkg;

   localparam int DEF_DEBOUNCE = 16;

   // Sticky flag update: a same-cycle set beats a clear so no press is lost.
   function automatic logic evt_next(
      input logic cur,
      input logic clr,
      input logic set
   );
      return (cur & ~clr) | set;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: two-flop sync, polarity fix, counter debounce, edges.
module debounce_channel
   import gpio_input_capture_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE,
   parameter logic ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic rstn,
   input  logic pin,
   output logic rise,
   output logic level,
   output logic press,
   output logic released
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1;
   logic          s2;
   logic          norm;
   logic          accept;
   logic          level_next;
   logic [CW-1:0] cnt;

   assign norm       = s2 ^ ACTIVE_LOW;
   assign accept     = (norm != level) && (cnt == LAST);
   assign level_next = accept ? norm : level;
   assign rise       = level_next & ~level;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         s1       <= ACTIVE_LOW;
         s2       <= ACTIVE_LOW;
         cnt      <= '0;
         level    <= 1'b0;
         press    <= 1'b0;
         released <= 1'b0;
      end else begin
         s1 <= pin;
         s2 <= s1;
         // Any agreeing sample restarts the stability count.
         if (norm == level || accept) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
         level    <= level_next;
         press    <= level_next & ~level;
         released <= ~level_next & level;
      end
   end

endmodule

// File: rtl/gpio_input_capture.sv
// Debounced GPIO inputs with sticky press flags and a level interrupt.
module gpio_input_capture
   import gpio_input_capture_pkg::*;
#(
   parameter int           N               = 4,
   parameter int           DEBOUNCE_CYCLES = DEF_DEBOUNCE,
   parameter logic [N-1:0] ACTIVE_LOW      = {N{1'b1}}
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [N-1:0] pins_async,
   input  logic [N-1:0] irq_en,
   input  logic         clr_we,
   input  logic [N-1:0] clr_mask,
   output logic [N-1:0] level,
   output logic [N-1:0] press,
   output logic [N-1:0] released,
   output logic [N-1:0] events,
   output logic         irq
);

   logic [N-1:0] rise;
   logic [N-1:0] clr;
   logic [N-1:0] events_next;

   for (genvar i = 0; i < N; i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .ACTIVE_LOW      (ACTIVE_LOW[i])
      ) u_ch (
         .clk      (clk),
         .rstn     (rstn),
         .pin      (pins_async[i]),
         .rise     (rise[i]),
         .level    (level[i]),
         .press    (press[i]),
         .released (released[i])
      );
   end

   always_comb begin
      clr         = clr_we ? clr_mask : '0;
      events_next = '0;
      for (int i = 0; i < N; i++) begin
         events_next[i] = evt_next(events[i], clr[i], rise[i]);
      end
   end

   // irq follows next-state events so it rises with the flag itself.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         events <= '0;
         irq    <= 1'b0;
      end else begin
         events <= events_next;
         irq    <= |(events_next & irq_en);
      end
   end

endmodule

// File: tb/tb_gpio_input_capture.sv
// Randomized and directed bench for gpio_input_capture with a history model.
module tb_gpio_input_capture;

   localparam int N = 2;
   localparam int D = 4;
   localparam logic [1:0] AL = 2'b01;
   localparam int MAXC = 4096;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [1:0] pins_async = AL;
   logic [1:0] irq_en = 2'b00;
   logic       clr_we = 1'b0;
   logic [1:0] clr_mask = 2'b00;
   logic [1:0] level;
   logic [1:0] press;
   logic [1:0] released;
   logic [1:0] events;
   logic       irq;

   int n_cmp = 0;
   int n_err = 0;

   gpio_input_capture #(
      .N               (N),
      .DEBOUNCE_CYCLES (D),
      .ACTIVE_LOW      (AL)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .pins_async (pins_async),
      .irq_en     (irq_en),
      .clr_we     (clr_we),
      .clr_mask   (clr_mask),
      .level      (level),
      .press      (press),
      .released   (released),
      .events     (events),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [1:0] got,
                      input logic [1:0] exp, input int c);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%b want=%b", nm, c, got, exp);
      end
   endtask

   // Model: pin samples per edge, reset marks, and the window start per channel.
   logic       s1h [N][MAXC];
   logic       nh  [N][MAXC];
   bit         rsth[MAXC];
   int         start[N];
   logic [1:0] m_level = 2'b00;
   logic [1:0] m_press = 2'b00;
   logic [1:0] m_rel = 2'b00;
   logic [1:0] m_evt = 2'b00;
   logic       m_irq = 1'b0;
   int         cyc = 0;

   always begin
      @(posedge clk);
      cyc = cyc + 1;
      rsth[cyc] = !rstn;
      m_press = 2'b00;
      m_rel = 2'b00;
      if (!rstn) begin
         for (int ch = 0; ch < N; ch++) begin
            s1h[ch][cyc] = AL[ch];
            start[ch] = cyc + 1;
         end
         m_level = 2'b00;
         m_evt = 2'b00;
         m_irq = 1'b0;
      end else begin
         for (int ch = 0; ch < N; ch++) begin
            logic raw;
            bit all_diff;
            s1h[ch][cyc] = pins_async[ch];
            if (cyc < 3 || rsth[cyc-1])
               raw = AL[ch];
            else
               raw = s1h[ch][cyc-2];
            nh[ch][cyc] = raw ^ AL[ch];
            // Accept after D consecutive disagreeing samples since the last change.
            if (cyc - start[ch] + 1 >= D) begin
               all_diff = 1'b1;
               for (int j = cyc - D + 1; j <= cyc; j++)
                  if (nh[ch][j] == m_level[ch]) all_diff = 1'b0;
               if (all_diff) begin
                  if (m_level[ch]) m_rel[ch] = 1'b1;
                  else m_press[ch] = 1'b1;
                  m_level[ch] = ~m_level[ch];
                  start[ch] = cyc + 1;
               end
            end
         end
         m_evt = (m_evt & ~(clr_we ? clr_mask : 2'b00)) | m_press;
         m_irq = |(m_evt & irq_en);
      end
      #1;
      chk("m_level", level, m_level, cyc);
      chk("m_press", press, m_press, cyc);
      chk("m_release", released, m_rel, cyc);
      chk("m_events", events, m_evt, cyc);
      chk("m_irq", {1'b0, irq}, {1'b0, m_irq}, cyc);
   end

   task automatic lit(input string nm, input logic [1:0] got,
                      input logic [1:0] exp);
      chk(nm, got, exp, cyc);
   endtask

   task automatic nc(input int n);
      repeat (n) @(negedge clk);
   endtask

   int hold[N];

   initial begin
      rstn = 1'b0;
      pins_async = 2'b01;
      nc(3);
      lit("rst_level", level, 2'b00);
      lit("rst_press", press, 2'b00);
      lit("rst_release", released, 2'b00);
      lit("rst_events", events, 2'b00);
      lit("rst_irq", {1'b0, irq}, 2'b00);
      rstn = 1'b1;
      nc(3);
      lit("post_rst_level", level, 2'b00);

      pins_async[0] = 1'b0;
      nc(5);
      lit("press_early", level, 2'b00);
      nc(1);
      lit("press_level", level, 2'b01);
      lit("press_pulse", press, 2'b01);
      lit("press_event", events, 2'b01);
      nc(1);
      lit("press_gone", press, 2'b00);

      pins_async[1] = 1'b1;
      nc(3);
      pins_async[1] = 1'b0;
      nc(8);
      lit("glitch_level", level, 2'b01);
      lit("glitch_event", events, 2'b01);
      pins_async[1] = 1'b1;
      nc(5);
      lit("ch1_early", level, 2'b01);
      nc(1);
      lit("ch1_level", level, 2'b11);
      lit("ch1_press", press, 2'b10);

      clr_we = 1'b1;
      clr_mask = 2'b01;
      nc(1);
      clr_we = 1'b0;
      clr_mask = 2'b00;
      lit("clr_events", events, 2'b10);
      pins_async[0] = 1'b1;
      nc(7);
      lit("ch0_released", level, 2'b10);
      pins_async[0] = 1'b0;
      nc(5);
      clr_we = 1'b1;
      clr_mask = 2'b01;
      nc(1);
      clr_we = 1'b0;
      clr_mask = 2'b00;
      lit("collide_press", press, 2'b01);
      lit("collide_events", events, 2'b11);

      clr_we = 1'b1;
      clr_mask = 2'b01;
      irq_en = 2'b01;
      nc(1);
      clr_we = 1'b0;
      clr_mask = 2'b00;
      lit("gate_events", events, 2'b10);
      lit("gate_irq", {1'b0, irq}, 2'b00);
      irq_en = 2'b11;
      nc(1);
      lit("en_irq", {1'b0, irq}, 2'b01);
      clr_we = 1'b1;
      clr_mask = 2'b10;
      nc(1);
      clr_we = 1'b0;
      clr_mask = 2'b00;
      lit("clr_irq", {1'b0, irq}, 2'b00);

      pins_async = 2'b01;
      nc(8);
      lit("idle_level", level, 2'b00);
      pins_async[0] = 1'b0;
      nc(4);
      rstn = 1'b0;
      nc(1);
      rstn = 1'b1;
      lit("midrst_level", level, 2'b00);
      nc(5);
      lit("midrst_early", level, 2'b00);
      nc(1);
      lit("midrst_level2", level, 2'b01);
      lit("midrst_press", press, 2'b01);

      for (int ch = 0; ch < N; ch++) hold[ch] = 0;
      for (int t = 0; t < 1500; t++) begin
         @(negedge clk);
         for (int ch = 0; ch < N; ch++) begin
            if (hold[ch] == 0) begin
               pins_async[ch] = ~pins_async[ch];
               hold[ch] = $urandom_range(1, 9);
            end else begin
               hold[ch] = hold[ch] - 1;
            end
         end
         clr_we = ($urandom_range(0, 7) == 0);
         clr_mask = 2'($urandom);
         if ($urandom_range(0, 15) == 0) irq_en = 2'($urandom);
         rstn = ($urandom_range(0, 199) != 0);
      end
      rstn = 1'b1;
      nc(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/gpio_input_capture.md
Name: gpio_input_capture

Overview:
- Input-direction counterpart of the CPU's io_out→LED path: turns raw asynchronous board inputs (push-buttons such as key) into clean, CPU-readable state for io_in.
- Per channel: two-flop synchronization, polarity normalization, counter-based debounce, and press/release edge detection.
- Sticky press flags that the CPU clears with write-1-to-clear, plus a level interrupt.
- Sits between top-level pins and the cpu io_in bus, clocked on the CPU clock.

Parameters:
- N, default 4: number of input channels.
- DEBOUNCE_CYCLES, default 16: consecutive stable synchronized cycles required before a level change is accepted; legal range ≥1.
- ACTIVE_LOW, default {N{1'b1}}: per-channel mask; bit=1 means the pin reads 0 when pressed and is inverted internally.

Ports:
- clk  in  1  CPU clock; all state on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- pins_async  in  N  raw asynchronous pin levels.
- irq_en  in  N  per-channel interrupt enable.
- clr_we  in  1  event-clear strobe, one cycle.
- clr_mask  in  N  write-1-to-clear mask, sampled when clr_we=1.
- level  out  N  debounced, normalized level; 1 means pressed.
- press  out  N  one-cycle pulse when level rises.
- release  out  N  one-cycle pulse when level falls.
- events  out  N  sticky press flags.
- irq  out  1  |(events & irq_en), registered.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - Sync flops load the inactive raw level: ACTIVE_LOW bit → 1, else 0.
  - level, press, release, events, irq are 0; debounce counters are 0.
  - Reset has priority over all other inputs.
  - Reset mid-debounce discards the partial count.
- Synchronizer:
  - s1 <= pins_async; s2 <= s1.
  - norm = s2 ^ ACTIVE_LOW.
- Debounce, per channel, with counter cnt of width clog2(DEBOUNCE_CYCLES+1):
  - If norm == level, then cnt <= 0.
  - Else, if cnt == DEBOUNCE_CYCLES-1, then level <= norm and cnt <= 0.
  - Else cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes level; any single agreeing sample restarts the count.
  - Latency from a clean pin edge to level change is 2 + DEBOUNCE_CYCLES clk cycles.
  - The counter never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.
- Edges:
  - press = registered (level_next & ~level); release = registered (~level_next & level).
  - Each pulses high for exactly one cycle, in the same cycle level first shows the new value.
  - press and release are never high together on one channel.
- Events:
  - events[i] <= (events[i] & ~(clr_we & clr_mask[i])) | press_set[i].
  - press_set is the same-cycle press condition.
  - A simultaneous set and clear leaves the bit set (set wins), so no press is lost.
  - clr_we=0 ignores clr_mask.
  - A repeated press while the bit is already set keeps it 1; there is no counter.
- irq:
  - Registered from the next-state events & irq_en, so it is high in the same cycle the event bit becomes 1.
  - Deasserts the cycle after the clear, or after the irq_en bit drops.
- Channels are fully independent; there is no cross-channel interaction.
- No FSM beyond the per-channel counter; the stable/unstable state is implied by cnt != 0.

Decomposition:
- Sub-module debounce_channel (one instance per channel via generate). It holds:
  - synchronizer
  - counter
  - level
  - press and release registers
  - parameters DEBOUNCE_CYCLES and ACTIVE_LOW (1 bit)
- Parent gpio_input_capture holds events, irq, and the clear logic.
- No shared package types are required.
- Counter width is a localparam computed with $clog2 in debounce_channel.

Test Plan (bench uses N=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=2'b01):
- Reset: hold rstn=0 3 cycles with pins_async=2'b01 → all outputs 0; after release, level stays 2'b00.
- Clean press ch0: drive pins_async[0] 1→0 at cycle 0 → level[0]=1 and press[0]=1 at cycle 6; events[0]=1 from cycle 6; press[0]=0 at cycle 7.
- Glitch reject ch1: pulse pins_async[1] high for 3 cycles then low → level[1], press[1], events[1] stay 0 throughout. Then hold high 4+ cycles → level[1]=1 at 2+4 cycles after the edge.
- Clear/set collision: with events[0]=1, assert clr_we=1, clr_mask=2'b01 in a cycle with no press → events[0]=0 next cycle. Repeat in the cycle press[0] fires → events[0] remains 1.
- irq gating: events=2'b10, irq_en=2'b01 → irq=0. Set irq_en=2'b11 → irq=1 next cycle. Clear with clr_mask=2'b10 → irq=0 the cycle after.
- Reset mid-debounce: after 2 cycles of a stable new ch0 level, pulse rstn=0 for 1 cycle → no press. Count restarts, and level[0]=1 appears 2+4 cycles after rstn returns high with the pin held pressed.
